// File: rtl/mem_stage_rdbuf_pkg.sv
// Shared constants for the memory stage:
//   - bit indices of the one-hot load/store op vector {lwr,lwl,lw,lhu,lh,lbu,lb,nonload}
//   - positions of the upstream exception flags and the CP0 exception codes they map to
//   - location of the pc inside the pass-through sideband
package mem_stage_rdbuf_pkg;

  // One-hot op vector bit indices.
  localparam int unsigned OpNonload = 0;
  localparam int unsigned OpLb      = 1;
  localparam int unsigned OpLbu     = 2;
  localparam int unsigned OpLh      = 3;
  localparam int unsigned OpLhu     = 4;
  localparam int unsigned OpLw      = 5;
  localparam int unsigned OpLwl     = 6;
  localparam int unsigned OpLwr     = 7;
  localparam int unsigned OpW       = 8;

  // Every op other than nonload waits for a response beat.
  localparam logic [OpW-1:0] LoadOpMask = 8'hFE;

  // Upstream exception flag positions.
  localparam int unsigned ExcBitSyscall   = 8;
  localparam int unsigned ExcBitRi        = 9;
  localparam int unsigned ExcBitTrap      = 10;
  localparam int unsigned ExcBitOv        = 11;
  localparam int unsigned ExcBitEret      = 12;
  localparam int unsigned ExcBitBreak     = 13;
  localparam int unsigned ExcBitAdes      = 14;
  localparam int unsigned ExcBitLoadAdel  = 15;
  localparam int unsigned ExcBitFetchAdel = 16;

  // CP0 exception codes.
  localparam logic [31:0] ExcCodeNone = 32'h00;
  localparam logic [31:0] ExcCodeInt  = 32'h01;
  localparam logic [31:0] ExcCodeAdel = 32'h04;
  localparam logic [31:0] ExcCodeAdes = 32'h05;
  localparam logic [31:0] ExcCodeSys  = 32'h08;
  localparam logic [31:0] ExcCodeBp   = 32'h09;
  localparam logic [31:0] ExcCodeRi   = 32'h0a;
  localparam logic [31:0] ExcCodeOv   = 32'h0c;
  localparam logic [31:0] ExcCodeTr   = 32'h0d;
  localparam logic [31:0] ExcCodeEret = 32'h0e;

  // CP0 Status bits.
  localparam int unsigned StatusIe  = 0;
  localparam int unsigned StatusExl = 1;

  // The pc occupies the low 32 bits of the sideband.
  localparam int unsigned MetaPcLsb = 0;

endpackage

// File: rtl/mem_stage_rdbuf_fifo.sv
// rdbuf_fifo: synchronous FIFO holding load response words.
//   clk, rst   clock, synchronous active-high reset
//   clr        empties the FIFO (pointers and count) on the next edge
//   push/wdata write a word; ignored when full
//   pop/rdata  rdata is the head entry; pop ignored when empty
//   count      number of stored entries
//   full/empty status flags
//   ovf        pulse: push attempted while full (beat dropped)
module rdbuf_fifo #(
  parameter int unsigned BUF_DEPTH = 2,
  parameter int unsigned DATA_W    = 32,
  localparam int unsigned PtrW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1,
  localparam int unsigned CntW = $clog2(BUF_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic [CntW-1:0]   count,
  output logic              full,
  output logic              empty,
  output logic              ovf
);

  logic [DATA_W-1:0] mem_q [BUF_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              do_push, do_pop;

  // Pointers wrap modulo BUF_DEPTH, which need not fill the pointer width.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(BUF_DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full    = (count_q == CntW'(BUF_DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign ovf     = push & full;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/mem_stage_rdbuf.sv
// mem_stage_rdbuf: memory pipeline stage between the load response path and write-back.
// Holds one instruction, buffers load responses, aligns load data and prioritises exceptions.
//   clk, rst, flush                  clock, sync active-high reset, pipeline flush
//   in_valid/in_ready, in_*          instruction from the previous stage
//   rsp_valid, rsp_data              load response beats
//   cp0_status, cp0_cause            live CP0 state for interrupt detection
//   out_valid/out_ready, out_*       result to write-back (out_* read 0 while stage is empty)
//   buf_ovf                          sticky: a response beat was dropped on a full buffer
// Alignment logic is written for DATA_W = 32.
module mem_stage_rdbuf
  import mem_stage_rdbuf_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned BUF_DEPTH = 2,
  parameter int unsigned META_W    = 160
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_op,
  input  logic [31:0]       in_addr,
  input  logic [DATA_W-1:0] in_rt_old,
  input  logic              in_we,
  input  logic [4:0]        in_waddr,
  input  logic [31:0]       in_exc,
  input  logic [META_W-1:0] in_meta,
  input  logic              rsp_valid,
  input  logic [DATA_W-1:0] rsp_data,
  input  logic [31:0]       cp0_status,
  input  logic [31:0]       cp0_cause,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_we,
  output logic [4:0]        out_waddr,
  output logic [DATA_W-1:0] out_wdata,
  output logic [31:0]       out_exccode,
  output logic [META_W-1:0] out_meta,
  output logic              buf_ovf
);

  localparam int unsigned CntW = $clog2(BUF_DEPTH + 1);

  logic              stage_valid_q, stage_valid_d;
  logic [7:0]        op_q;
  logic [31:0]       addr_q;
  logic [DATA_W-1:0] rt_old_q;
  logic              we_q;
  logic [4:0]        waddr_q;
  logic [31:0]       exc_q;
  logic [META_W-1:0] meta_q;
  logic              buf_ovf_q;

  logic              is_load, accept, retire, bypass;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty, fifo_ovf;
  logic [DATA_W-1:0] fifo_rdata, load_data;
  logic [CntW-1:0]   fifo_count;
  logic [31:0]       exccode, pc;

  function automatic logic [31:0] align_load(input logic [7:0] op, input logic [31:0] addr,
                                             input logic [31:0] data, input logic [31:0] rt_old);
    logic [1:0]  a;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] mask;
    logic [31:0] res;
    a    = addr[1:0];
    b    = 8'(data >> {a, 3'b000});
    h    = a[1] ? data[31:16] : data[15:0];
    mask = '0;
    res  = addr;
    unique case (1'b1)
      op[OpLb]:  res = {{24{b[7]}}, b};
      op[OpLbu]: res = {24'h0, b};
      op[OpLh]:  res = a[0] ? '0 : {{16{h[15]}}, h};
      op[OpLhu]: res = a[0] ? '0 : {16'h0, h};
      op[OpLw]:  res = data;
      op[OpLwl]: begin
        // Shift by 3-a bytes; ~a equals 3-a for a 2-bit offset.
        mask = 32'hFFFF_FFFF << {~a, 3'b000};
        res  = (data << {~a, 3'b000}) | (rt_old & ~mask);
      end
      op[OpLwr]: begin
        mask = 32'hFFFF_FFFF >> {a, 3'b000};
        res  = (data >> {a, 3'b000}) | (rt_old & ~mask);
      end
      default:   res = addr;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] exc_prio(input logic [31:0] exc, input logic [31:0] status,
                                           input logic [31:0] cause);
    logic [31:0] code;
    if ((|(cause[15:8] & status[15:8])) && !status[StatusExl] && status[StatusIe]) begin
      code = ExcCodeInt;
    end else if (exc[ExcBitFetchAdel]) code = ExcCodeAdel;
    else if (exc[ExcBitRi])            code = ExcCodeRi;
    else if (exc[ExcBitSyscall])       code = ExcCodeSys;
    else if (exc[ExcBitBreak])         code = ExcCodeBp;
    else if (exc[ExcBitTrap])          code = ExcCodeTr;
    else if (exc[ExcBitOv])            code = ExcCodeOv;
    else if (exc[ExcBitEret])          code = ExcCodeEret;
    else if (exc[ExcBitAdes])          code = ExcCodeAdes;
    else if (exc[ExcBitLoadAdel])      code = ExcCodeAdel;
    else                               code = ExcCodeNone;
    return code;
  endfunction

  // Handshake and response routing. A response that arrives while the
  // waiting load retires goes straight through (bypass) instead of the FIFO.
  assign is_load   = |(op_q & LoadOpMask);
  assign bypass    = rsp_valid & fifo_empty;
  assign out_valid = stage_valid_q & (~is_load | ~fifo_empty | bypass);
  assign retire    = out_valid & out_ready;
  assign in_ready  = ~stage_valid_q | retire;
  assign accept    = in_valid & in_ready & ~flush;
  assign load_data = fifo_empty ? rsp_data : fifo_rdata;
  assign fifo_pop  = retire & is_load & ~fifo_empty & ~flush;
  assign fifo_push = rsp_valid & ~flush & ~(retire & is_load & fifo_empty);

  always_comb begin
    stage_valid_d = stage_valid_q;
    if (flush)       stage_valid_d = 1'b0;
    else if (accept) stage_valid_d = 1'b1;
    else if (retire) stage_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_valid_q <= 1'b0;
      op_q          <= '0;
      addr_q        <= '0;
      rt_old_q      <= '0;
      we_q          <= 1'b0;
      waddr_q       <= '0;
      exc_q         <= '0;
      meta_q        <= '0;
      buf_ovf_q     <= 1'b0;
    end else begin
      stage_valid_q <= stage_valid_d;
      if (accept) begin
        op_q     <= in_op;
        addr_q   <= in_addr;
        rt_old_q <= in_rt_old;
        we_q     <= in_we;
        waddr_q  <= in_waddr;
        exc_q    <= in_exc;
        meta_q   <= in_meta;
      end
      if (fifo_ovf) buf_ovf_q <= 1'b1;
    end
  end

  rdbuf_fifo #(
    .BUF_DEPTH (BUF_DEPTH),
    .DATA_W    (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (flush),
    .push  (fifo_push),
    .wdata (rsp_data),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty),
    .ovf   (fifo_ovf)
  );

  assign pc      = meta_q[MetaPcLsb +: 32];
  assign exccode = (stage_valid_q && pc != '0) ? exc_prio(exc_q, cp0_status, cp0_cause)
                                               : ExcCodeNone;

  always_comb begin
    out_we      = stage_valid_q & we_q & (exccode == ExcCodeNone);
    out_waddr   = stage_valid_q ? waddr_q : '0;
    out_wdata   = stage_valid_q ? DATA_W'(align_load(op_q, addr_q, 32'(load_data),
                                                     32'(rt_old_q))) : '0;
    out_exccode = exccode;
    out_meta    = stage_valid_q ? meta_q : '0;
    buf_ovf     = buf_ovf_q;
  end

endmodule

// File: tb/tb_mem_stage_rdbuf.sv
module tb_mem_stage_rdbuf;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned BUF_DEPTH = 2;
  localparam int unsigned META_W    = 160;

  localparam logic [7:0] OP_NL  = 8'h01, OP_LB  = 8'h02, OP_LBU = 8'h04, OP_LH  = 8'h08;
  localparam logic [7:0] OP_LHU = 8'h10, OP_LW  = 8'h20, OP_LWL = 8'h40, OP_LWR = 8'h80;
  localparam logic [31:0] PC = 32'hBFC0_0100;

  localparam int ExcBit [9] = '{16, 9, 8, 13, 10, 11, 12, 14, 15};
  localparam int ExcVal [9] = '{4, 10, 8, 9, 13, 12, 14, 5, 4};

  logic clk = 0, rst = 1, flush = 0;
  logic in_valid = 0, in_ready, in_we = 0, rsp_valid = 0, out_valid, out_ready = 0, out_we;
  logic buf_ovf;
  logic [7:0] in_op = 0;
  logic [31:0] in_addr = 0, in_exc = 0, cp0_status = 0, cp0_cause = 0, out_exccode;
  logic [DATA_W-1:0] in_rt_old = 0, rsp_data = 0, out_wdata;
  logic [4:0] in_waddr = 0, out_waddr;
  logic [META_W-1:0] in_meta = 0, out_meta;

  always #5 clk = ~clk;

  mem_stage_rdbuf #(.DATA_W(DATA_W), .BUF_DEPTH(BUF_DEPTH), .META_W(META_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_addr(in_addr), .in_rt_old(in_rt_old), .in_we(in_we),
    .in_waddr(in_waddr), .in_exc(in_exc), .in_meta(in_meta), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .cp0_status(cp0_status), .cp0_cause(cp0_cause),
    .out_valid(out_valid), .out_ready(out_ready), .out_we(out_we), .out_waddr(out_waddr),
    .out_wdata(out_wdata), .out_exccode(out_exccode), .out_meta(out_meta), .buf_ovf(buf_ovf)
  );

  int n_total = 0, n_pass = 0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    else n_pass++;
  endtask

  // ---------------- reference model ----------------
  logic              m_valid = 0, m_we = 0, m_ovf = 0;
  logic [7:0]        m_op = 0;
  logic [31:0]       m_addr = 0, m_rt = 0, m_exc = 0;
  logic [4:0]        m_waddr = 0;
  logic [META_W-1:0] m_meta = 0;
  logic [31:0]       m_q[$];
  logic              e_out_valid, e_in_ready, e_we;
  logic [31:0]       e_wdata, e_code;

  function automatic logic [31:0] m_align(input logic [7:0] op, input logic [31:0] addr,
                                          input logic [31:0] rt, input logic [31:0] data);
    logic [7:0] d[4], r[4], o[4];
    logic [15:0] h;
    int a;
    a = int'(addr[1:0]);
    for (int i = 0; i < 4; i++) begin
      d[i] = data[8*i +: 8];
      r[i] = rt[8*i +: 8];
    end
    case (op)
      OP_LB:  return d[a][7] ? (32'hFFFF_FF00 | 32'(d[a])) : 32'(d[a]);
      OP_LBU: return 32'(d[a]);
      OP_LH, OP_LHU: begin
        if (a == 0)      h = {d[1], d[0]};
        else if (a == 2) h = {d[3], d[2]};
        else return 32'h0;
        return (op == OP_LH && h[15]) ? (32'hFFFF_0000 | 32'(h)) : 32'(h);
      end
      OP_LW: return data;
      OP_LWL: begin
        for (int i = 0; i < 4; i++) o[i] = (i >= 3 - a) ? d[i - (3 - a)] : r[i];
        return {o[3], o[2], o[1], o[0]};
      end
      OP_LWR: begin
        for (int i = 0; i < 4; i++) o[i] = (i <= 3 - a) ? d[i + a] : r[i];
        return {o[3], o[2], o[1], o[0]};
      end
      default: return addr;
    endcase
  endfunction

  function automatic logic [31:0] m_code();
    if (!m_valid || m_meta[31:0] == 0) return 0;
    if ((cp0_cause[15:8] & cp0_status[15:8]) != 0 && !cp0_status[1] && cp0_status[0]) return 1;
    for (int k = 0; k < 9; k++) if (m_exc[ExcBit[k]]) return 32'(ExcVal[k]);
    return 0;
  endfunction

  function automatic void eval_model();
    logic ld;
    logic [31:0] d;
    ld = m_valid && (m_op != OP_NL);
    d = (m_q.size() != 0) ? m_q[0] : rsp_data;
    e_out_valid = m_valid && (!ld || m_q.size() != 0 || rsp_valid);
    e_in_ready = !m_valid || (e_out_valid && out_ready);
    e_code = m_code();
    e_we = m_valid && m_we && (e_code == 0);
    e_wdata = m_align(m_op, m_addr, m_rt, d);
  endfunction

  always @(posedge clk) begin
    logic ld, ret, was_full, took;
    if (rst) begin
      m_valid = 0; m_ovf = 0; m_q.delete();
    end else if (flush) begin
      m_valid = 0; m_q.delete();
    end else begin
      eval_model();
      ld = m_valid && (m_op != OP_NL);
      ret = e_out_valid && out_ready;
      was_full = (m_q.size() == BUF_DEPTH);
      took = 0;
      if (ret && ld) begin
        if (m_q.size() != 0) void'(m_q.pop_front());
        else took = 1;
      end
      if (rsp_valid && !took) begin
        if (was_full) m_ovf = 1;
        else m_q.push_back(rsp_data);
      end
      if (in_valid && e_in_ready) begin
        m_valid = 1; m_op = in_op; m_addr = in_addr; m_rt = in_rt_old; m_we = in_we;
        m_waddr = in_waddr; m_exc = in_exc; m_meta = in_meta;
      end else if (ret) m_valid = 0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      eval_model();
      chk("mon_out_valid", out_valid, e_out_valid);
      chk("mon_in_ready", in_ready, e_in_ready);
      chk("mon_buf_ovf", buf_ovf, m_ovf);
      if (m_valid) begin
        chk("mon_exccode", out_exccode, e_code);
        chk("mon_we", out_we, e_we);
        chk("mon_waddr", out_waddr, m_waddr);
        chk("mon_meta", out_meta, m_meta);
      end
      if (e_out_valid) chk("mon_wdata", out_wdata, e_wdata);
    end
  end

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [7:0]  op;
    logic [31:0] addr, rt, data, exc, status, cause, pc;
    logic [31:0] exp_wdata, exp_code;
    logic        exp_we;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs = '{
      '{OP_LW,  32'h1000, 0, 32'hDEADBEEF, 0, 0, 0, PC, 32'hDEADBEEF, 0, 1},
      '{OP_LB,  32'h1003, 0, 32'h80112233, 0, 0, 0, PC, 32'hFFFFFF80, 0, 1},
      '{OP_LBU, 32'h1003, 0, 32'h80112233, 0, 0, 0, PC, 32'h00000080, 0, 1},
      '{OP_LB,  32'h1000, 0, 32'h80112233, 0, 0, 0, PC, 32'h00000033, 0, 1},
      '{OP_LH,  32'h1002, 0, 32'h80112233, 0, 0, 0, PC, 32'hFFFF8011, 0, 1},
      '{OP_LHU, 32'h1000, 0, 32'h8011F233, 0, 0, 0, PC, 32'h0000F233, 0, 1},
      '{OP_LH,  32'h1001, 0, 32'h80112233, 0, 0, 0, PC, 32'h00000000, 0, 1},
      '{OP_LWL, 32'h1001, 32'h11223344, 32'hAABBCCDD, 0, 0, 0, PC, 32'hCCDD3344, 0, 1},
      '{OP_LWR, 32'h1001, 32'h11223344, 32'hAABBCCDD, 0, 0, 0, PC, 32'h11AABBCC, 0, 1},
      '{OP_LWL, 32'h1000, 32'h11223344, 32'hAABBCCDD, 0, 0, 0, PC, 32'hDD223344, 0, 1},
      '{OP_LWR, 32'h1003, 32'h11223344, 32'hAABBCCDD, 0, 0, 0, PC, 32'h112233AA, 0, 1},
      '{OP_NL,  32'h12345678, 0, 0, 0, 0, 0, PC, 32'h12345678, 0, 1},
      '{OP_LW,  32'h1000, 0, 32'h01020304, 32'h200, 32'hFF01, 32'h400, PC, 32'h01020304, 1, 0},
      '{OP_NL,  32'h40, 0, 0, 32'h200, 0, 0, PC, 32'h40, 32'h0a, 0},
      '{OP_NL,  32'h40, 0, 0, 32'h10200, 0, 0, PC, 32'h40, 32'h04, 0},
      '{OP_NL,  32'h40, 0, 0, 32'hC000, 0, 0, PC, 32'h40, 32'h05, 0},
      '{OP_NL,  32'h40, 0, 0, 32'h8000, 0, 0, PC, 32'h40, 32'h04, 0},
      '{OP_NL,  32'h40, 0, 0, 32'h200, 32'hFF03, 32'h400, PC, 32'h40, 32'h0a, 0},
      '{OP_NL,  32'h40, 0, 0, 32'h2400, 0, 0, PC, 32'h40, 32'h09, 0},
      '{OP_NL,  32'h40, 0, 0, 32'h200, 0, 0, 32'h0, 32'h40, 32'h00, 1},
      '{OP_NL,  32'h40, 0, 0, 32'h100, 32'hFF00, 32'h400, PC, 32'h40, 32'h08, 0}
    };

    repeat (3) tick();
    rst = 0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_we", out_we, 0);
    chk("rst_out_wdata", out_wdata, 0);
    chk("rst_out_exccode", out_exccode, 0);
    chk("rst_out_waddr", out_waddr, 0);
    chk("rst_out_meta", out_meta, 0);
    chk("rst_buf_ovf", buf_ovf, 0);

    foreach (vecs[i]) begin
      tick();
      in_valid = 1; in_op = vecs[i].op; in_addr = vecs[i].addr; in_rt_old = vecs[i].rt;
      in_we = 1; in_waddr = 5'(i + 1); in_exc = vecs[i].exc; in_meta = {128'h0, vecs[i].pc};
      cp0_status = vecs[i].status; cp0_cause = vecs[i].cause; out_ready = 1; rsp_valid = 0;
      tick();
      in_valid = 0;
      if (vecs[i].op != OP_NL) begin rsp_valid = 1; rsp_data = vecs[i].data; end
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), out_valid, 1);
      chk($sformatf("vec%0d_wdata", i), out_wdata, vecs[i].exp_wdata);
      chk($sformatf("vec%0d_exccode", i), out_exccode, vecs[i].exp_code);
      chk($sformatf("vec%0d_we", i), out_we, vecs[i].exp_we);
      chk($sformatf("vec%0d_fifo_empty", i), dut.fifo_count, 0);
      tick();
      rsp_valid = 0;
    end
    cp0_status = 0; cp0_cause = 0; in_exc = 0; in_meta = {128'h0, PC};

    // LB stalled by write-back: response must be buffered and held.
    tick();
    out_ready = 0; in_valid = 1; in_op = OP_LB; in_addr = 32'h1003;
    tick();
    in_valid = 0; rsp_valid = 1; rsp_data = 32'h80112233;
    tick();
    rsp_valid = 0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_valid", out_valid, 1);
      chk("stall_wdata", out_wdata, 32'hFFFFFF80);
      chk("stall_count", dut.fifo_count, 1);
      tick();
    end
    out_ready = 1;
    @(negedge clk);
    chk("release_valid", out_valid, 1);
    chk("release_wdata", out_wdata, 32'hFFFFFF80);
    tick();
    @(negedge clk);
    chk("release_done", out_valid, 0);
    chk("release_count", dut.fifo_count, 0);

    // Overflow: third beat dropped, flag sticky through flush, cleared by reset.
    tick();
    out_ready = 0; rsp_valid = 1; rsp_data = 1;
    tick(); rsp_data = 2;
    tick(); rsp_data = 3;
    tick(); rsp_valid = 0;
    @(negedge clk);
    chk("ovf_set", buf_ovf, 1);
    chk("ovf_count", dut.fifo_count, 2);
    tick(); flush = 1;
    tick(); flush = 0;
    @(negedge clk);
    chk("ovf_sticky", buf_ovf, 1);
    chk("ovf_flushed_count", dut.fifo_count, 0);
    tick(); rst = 1;
    tick(); rst = 0;
    @(negedge clk);
    chk("ovf_cleared", buf_ovf, 0);

    // Flush with a buffered entry and a held load.
    tick();
    out_ready = 0; in_valid = 1; in_op = OP_LW; in_addr = 32'h1000;
    tick();
    in_valid = 0; rsp_valid = 1; rsp_data = 32'h11111111;
    tick();
    rsp_valid = 0; flush = 1;
    tick();
    flush = 0;
    @(negedge clk);
    chk("flush_valid", out_valid, 0);
    chk("flush_count", dut.fifo_count, 0);
    chk("flush_in_ready", in_ready, 1);
    tick();
    in_valid = 1; in_op = OP_LW; out_ready = 1;
    tick();
    in_valid = 0; rsp_valid = 1; rsp_data = 32'h22222222;
    @(negedge clk);
    chk("post_flush_valid", out_valid, 1);
    chk("post_flush_wdata", out_wdata, 32'h22222222);
    tick();
    rsp_valid = 0;
    // Flush beats a simultaneous accept.
    tick();
    in_valid = 1; in_op = OP_NL; flush = 1;
    tick();
    in_valid = 0; flush = 0;
    @(negedge clk);
    chk("flush_vs_accept", out_valid, 0);

    // Randomised traffic against the model.
    tick(); rst = 1;
    tick(); rst = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      in_valid = ($urandom_range(0, 9) < 6);
      in_op = 8'(8'h01 << $urandom_range(0, 7));
      in_addr = $urandom;
      in_rt_old = $urandom;
      in_we = ($urandom_range(0, 3) != 0);
      in_waddr = 5'($urandom);
      in_exc = ($urandom_range(0, 3) == 0) ?
               ((32'h1 << $urandom_range(8, 16)) | (32'h1 << $urandom_range(8, 16))) : 32'h0;
      in_meta = {$urandom, $urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 7) == 0) in_meta[31:0] = 0;
      rsp_valid = ($urandom_range(0, 9) < 3);
      rsp_data = $urandom;
      flush = ($urandom_range(0, 99) < 3);
      out_ready = ($urandom_range(0, 9) < 7);
      cp0_status = {16'h0, 8'($urandom), 6'h0, 2'($urandom)};
      cp0_cause = ($urandom_range(0, 3) == 0) ? (32'h1 << $urandom_range(8, 15)) : 32'h0;
    end
    tick();
    in_valid = 0; rsp_valid = 0; flush = 0;
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_stage_rdbuf.md
Name: mem_stage_rdbuf

Overview:
- Parametrised next-generation memory stage that sits between the data-cache/AXI response path and the write-back stage.
- Holds one instruction in a stage register with valid/ready handshakes on both sides.
- Queues load response data in a BUF_DEPTH FIFO, so responses that arrive while the stage is stalled are never lost.
- Performs byte/half/word/LWL/LWR load alignment and produces the prioritised exception code for the CP0 path.

Parameters:
- DATA_W, 32, width of load data and register write data; legal values 32 only for MIPS32 ops, 64 reserved.
- BUF_DEPTH, 2, number of load response entries in the FIFO; power of two, ≥1.
- META_W, 160, width of the pass-through sideband (pc, hilo, cp0 bus, delay-slot bit, bad vaddr).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  pipeline flush (exception/eret)
- in_valid  in  1  instruction offered by the previous stage
- in_ready  out  1  stage register can accept
- in_op  in  8  one-hot {lwr,lwl,lw,lhu,lh,lbu,lb,nonload}
- in_addr  in  32  effective address / ALU result
- in_rt_old  in  DATA_W  old rt value for LWL/LWR merge
- in_we  in  1  register write enable
- in_waddr  in  5  register write address
- in_exc  in  32  upstream exception flag vector
- in_meta  in  META_W  sideband, passed unchanged
- rsp_valid  in  1  load response beat
- rsp_data  in  DATA_W  load response word
- cp0_status  in  32  CP0 Status
- cp0_cause  in  32  CP0 Cause
- out_valid  out  1  result valid to write-back
- out_ready  in  1  write-back accepts
- out_we  out  1  write enable, forced 0 when out_exccode≠0
- out_waddr  out  5  write address
- out_wdata  out  DATA_W  write data
- out_exccode  out  32  exception code
- out_meta  out  META_W  sideband
- buf_ovf  out  1  sticky FIFO overflow error

Behaviour:
Reset:
- Clears the stage register valid bit, FIFO pointers and count, and buf_ovf.
- All outputs read 0 after reset, except in_ready, which reads 1.

Stage register:
- in_ready = ~stage_valid | (out_valid & out_ready).
- Load occurs on in_valid & in_ready; latency is 1 cycle from acceptance to out_valid for non-loads.
- When no new instruction is loaded and the held one retires, stage_valid clears.

Load wait:
- For a load op, out_valid = stage_valid & (fifo_count≠0 | bypass), where bypass = rsp_valid & fifo empty.
- The head entry (or bypass data) is consumed in the same cycle as out_valid & out_ready.
- Non-loads never consume FIFO entries.

FIFO:
- Push on rsp_valid unless that beat is bypass-consumed in the same cycle.
- Simultaneous push and pop leaves count unchanged.
- Push when full drops the beat and sets buf_ovf, which stays set until rst.
- Read and write pointers wrap modulo BUF_DEPTH.

Flush:
- Clears stage_valid and empties the FIFO, effective the next cycle.
- A flush has priority over a simultaneous accept or rsp_valid.
- The producer guarantees no responses are outstanding when flush is raised.

Alignment (addr[1:0] = a):
- LB/LBU: select byte a, sign- or zero-extend.
- LH/LHU: a=0 selects bits 15:0, a=2 selects bits 31:16; other offsets give 0.
- LW: whole word.
- LWL: replace the top (a+1) bytes of rt_old with the low (a+1) bytes of the data, shifted left.
- LWR: replace the low (4-a) bytes of rt_old with the high (4-a) bytes of the data.
- Non-load: out_wdata = in_addr.

Exception priority (evaluated only when the stage is valid and pc≠0):
1. Interrupt, when (Cause[15:8] & Status[15:8])≠0, EXL=0 and IE=1: code 0x01.
2. exc[16] → 0x04
3. exc[9] → 0x0a
4. exc[8] → 0x08
5. exc[13] → 0x09
6. exc[10] → 0x0d
7. exc[11] → 0x0c
8. exc[12] → 0x0e
9. exc[14] → 0x05
10. exc[15] → 0x04
- Otherwise the code is 0.
- A load with a nonzero code still waits for and consumes its response.

Decomposition:
- Shared package: op one-hot bit indices, exception-code constants, exception vector bit positions.
- One natural sub-module: rdbuf_fifo (parametrised BUF_DEPTH/DATA_W synchronous FIFO exposing count, full, empty and an overflow pulse).
- Alignment and exception priority stay as combinational functions inside the top module.

Test Plan:
- LW at addr 0x1000, rsp_data 0xDEADBEEF in the accept+1 cycle, out_ready=1 → out_valid next cycle, out_wdata=0xDEADBEEF, FIFO stays empty (bypass).
- LB at addr 0x1003, rsp 0x80112233, out_ready held 0 for 3 cycles → response buffered (count=1), out_wdata=0xFFFFFF80 held stable, pops on release.
- BUF_DEPTH=2: three rsp_valid beats with out_ready=0 → third beat dropped, buf_ovf=1 and stays 1 until rst.
- LWL at a=1, rt_old=0x11223344, data 0xAABBCCDD → 0xCCDD3344; LWR at a=1 with the same inputs → 0x11AABBCC.
- Status=0x0000FF01, Cause=0x00000400, exc[9]=1 → out_exccode=0x01, out_we=0.
- Flush with one FIFO entry and a valid stage → next cycle out_valid=0, count=0, in_ready=1; a subsequent LW consumes only its own response.
